keyword_lexer: RTL and testbench

- Upstream stage of the begin/end block checker; sits between the raw ASCII byte stream and any token-level consumer.
- Consumes one character per clock when in_valid is high.
- Splits the stream into words on delimiters and classifies each completed word as BEGIN, END or OTHER, case-insensitively.
- Emits a one-cycle token pulse carrying the word's type and length, and keeps a saturating count of emitted tokens.

---
 rtl/keyword_lexer.sv | 131 +++++++++++++
 tb/tb_keyword_lexer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/keyword_lexer.sv
// keyword_lexer: splits an ASCII byte stream into words on space (and
// optionally tab) delimiters, and classifies each word as BEGIN, END or
// OTHER, ignoring letter case. Each completed word produces a one-cycle
// registered token pulse that carries the word's type and length. A
// saturating counter tracks how many tokens have been emitted.
module keyword_lexer #(
  parameter int LEN_W        = 8,
  parameter bit TAB_IS_SPACE = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             in_valid,
  input  logic             flush,
  output logic             tok_valid,
  output logic [1:0]       tok_type,
  output logic [LEN_W-1:0] tok_len,
  output logic [CNT_W-1:0] tok_cnt,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_KB1, S_KB2, S_KB3, S_KB4, S_KB5,
    S_KE1, S_KE2, S_KE3,
    S_WORD
  } state_t;

  typedef enum logic [1:0] {
    TOK_NONE  = 2'b00,
    TOK_BEGIN = 2'b01,
    TOK_END   = 2'b10,
    TOK_OTHER = 2'b11
  } tok_t;

  state_t           state, state_n;
  state_t           st_abs;
  logic [LEN_W-1:0] len_cnt, len_n, len_abs;
  logic             tok_valid_n;
  tok_t             tok_type_n;
  logic [LEN_W-1:0] tok_len_n;
  logic [CNT_W-1:0] tok_cnt_n;

  logic       is_letter, is_delim, word_char, delim_hit, term, hit;
  logic [7:0] lower, exp_ch;
  state_t     adv;

  // Byte classification: delimiters, letters and a lowercase folding.
  always_comb begin
    is_letter = ((in >= 8'h41) && (in <= 8'h5A)) || ((in >= 8'h61) && (in <= 8'h7A));
    lower     = in | 8'h20;
    is_delim  = (in == 8'h20) || (TAB_IS_SPACE && (in == 8'h09));
    word_char = in_valid && !is_delim;
    delim_hit = in_valid && is_delim;
  end

  // Next-state and token outputs. A word char on the same edge as flush is
  // absorbed first (st_abs/len_abs), and termination then acts on the result.
  always_comb begin
    exp_ch = 8'h00;
    adv    = S_WORD;
    unique case (state)
      S_KB1:   begin exp_ch = 8'h65; adv = S_KB2; end // e
      S_KB2:   begin exp_ch = 8'h67; adv = S_KB3; end // g
      S_KB3:   begin exp_ch = 8'h69; adv = S_KB4; end // i
      S_KB4:   begin exp_ch = 8'h6E; adv = S_KB5; end // n
      S_KE1:   begin exp_ch = 8'h6E; adv = S_KE2; end // n
      S_KE2:   begin exp_ch = 8'h64; adv = S_KE3; end // d
      default: begin exp_ch = 8'h00; adv = S_WORD; end
    endcase
    hit = is_letter && (lower == exp_ch) && (exp_ch != 8'h00);

    st_abs  = state;
    len_abs = len_cnt;
    if (word_char) begin
      len_abs = (len_cnt == '1) ? len_cnt : len_cnt + LEN_W'(1);
      if (state == S_IDLE) begin
        if (is_letter && (lower == 8'h62))      st_abs = S_KB1;
        else if (is_letter && (lower == 8'h65)) st_abs = S_KE1;
        else                                    st_abs = S_WORD;
      end else begin
        st_abs = hit ? adv : S_WORD;
      end
    end

    term = (st_abs != S_IDLE) && (delim_hit || flush);

    state_n     = term ? S_IDLE : st_abs;
    len_n       = term ? '0 : len_abs;
    tok_valid_n = term;
    tok_len_n   = term ? len_abs : '0;
    tok_type_n  = TOK_NONE;
    if (term) begin
      if (st_abs == S_KB5)      tok_type_n = TOK_BEGIN;
      else if (st_abs == S_KE3) tok_type_n = TOK_END;
      else                      tok_type_n = TOK_OTHER;
    end
    tok_cnt_n = (term && (tok_cnt != '1)) ? tok_cnt + CNT_W'(1) : tok_cnt;
  end

  // State register and running word length; reset discards any open word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      len_cnt <= '0;
    end else begin
      state   <= state_n;
      len_cnt <= len_n;
    end
  end

  // Registered token outputs and saturating token count.
  always_ff @(posedge clk) begin
    if (reset) begin
      tok_valid <= 1'b0;
      tok_type  <= TOK_NONE;
      tok_len   <= '0;
      tok_cnt   <= '0;
    end else begin
      tok_valid <= tok_valid_n;
      tok_type  <= tok_type_n;
      tok_len   <= tok_len_n;
      tok_cnt   <= tok_cnt_n;
    end
  end

  // Open-word indicator straight from the state register.
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_keyword_lexer.sv
// Directed testbench for keyword_lexer: a vector table drives the default
// configuration, and a hand-written sequence drives a narrow instance.
module tb_keyword_lexer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;

  logic        tok_valid;
  logic [1:0]  tok_type;
  logic [7:0]  tok_len;
  logic [15:0] tok_cnt;
  logic        busy;

  logic       tok_valid2;
  logic [1:0] tok_type2;
  logic [2:0] tok_len2;
  logic [1:0] tok_cnt2;
  logic       busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keyword_lexer dut (
    .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .flush(flush),
    .tok_valid(tok_valid), .tok_type(tok_type), .tok_len(tok_len),
    .tok_cnt(tok_cnt), .busy(busy)
  );

  keyword_lexer #(.LEN_W(3), .TAB_IS_SPACE(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .flush(flush),
    .tok_valid(tok_valid2), .tok_type(tok_type2), .tok_len(tok_len2),
    .tok_cnt(tok_cnt2), .busy(busy2)
  );

  typedef struct {
    logic [7:0]  c;
    logic        v;
    logic        f;
    logic        r;
    logic        ev;
    logic [1:0]  et;
    logic [7:0]  el;
    logic [15:0] ec;
    logic        eb;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [7:0] c, input logic v, input logic f, input logic r,
                     input logic ev, input logic [1:0] et, input logic [7:0] el,
                     input logic [15:0] ec, input logic eb);
    vec_t t;
    t.c = c; t.v = v; t.f = f; t.r = r;
    t.ev = ev; t.et = et; t.el = el; t.ec = ec; t.eb = eb;
    vq.push_back(t);
  endtask

  // Word characters that neither finish nor start a token: busy, no pulse.
  task automatic add_chars(input string s, input logic [15:0] cnt);
    for (int i = 0; i < s.len(); i++) add(s[i], 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, cnt, 1'b1);
  endtask

  task automatic step(input logic [7:0] c, input logic v, input logic f, input logic r);
    din = c; in_valid = v; flush = f; reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check2(input string name, input logic ev, input logic [1:0] et,
                        input logic [2:0] el, input logic [1:0] ec, input logic eb);
    checks++;
    if ({tok_valid2, tok_type2, tok_len2, tok_cnt2, busy2} !== {ev, et, el, ec, eb}) begin
      errors++;
      $display("FAIL %s: got v=%0b t=%b l=%0d c=%0d busy=%0b, expected v=%0b t=%b l=%0d c=%0d busy=%0b",
               name, tok_valid2, tok_type2, tok_len2, tok_cnt2, busy2, ev, et, el, ec, eb);
    end
  endtask

  initial begin
    // Reset state
    add(8'h00, 0, 0, 1, 0, 2'b00, 0, 0, 0);
    // "begin "
    add_chars("begin", 0);
    add(" ", 1, 0, 0, 1, 2'b01, 5, 1, 0);
    // "BeGiN EnD end "
    add(8'h00, 0, 0, 1, 0, 2'b00, 0, 0, 0);
    add_chars("BeGiN", 0);
    add(" ", 1, 0, 0, 1, 2'b01, 5, 1, 0);
    add_chars("EnD", 1);
    add(" ", 1, 0, 0, 1, 2'b10, 3, 2, 0);
    add_chars("end", 2);
    add(" ", 1, 0, 0, 1, 2'b10, 3, 3, 0);
    add("A", 0, 0, 0, 0, 2'b00, 0, 3, 0);
    // "beginx begi ends  en "
    add(8'h00, 0, 0, 1, 0, 2'b00, 0, 0, 0);
    add_chars("beginx", 0);
    add(" ", 1, 0, 0, 1, 2'b11, 6, 1, 0);
    add_chars("begi", 1);
    add(" ", 1, 0, 0, 1, 2'b11, 4, 2, 0);
    add_chars("ends", 2);
    add(" ", 1, 0, 0, 1, 2'b11, 4, 3, 0);
    add(" ", 1, 0, 0, 0, 2'b00, 0, 3, 0);
    add_chars("en", 3);
    add(" ", 1, 0, 0, 1, 2'b11, 2, 4, 0);
    // "end" with flush on the final char, then flushes while idle
    add_chars("en", 4);
    add("d", 1, 1, 0, 1, 2'b10, 3, 5, 0);
    add(8'h20, 0, 1, 0, 0, 2'b00, 0, 5, 0);
    add(" ", 1, 1, 0, 0, 2'b00, 0, 5, 0);
    add("q", 1, 1, 0, 1, 2'b11, 1, 6, 0);
    // "a b": two separate pulses
    add_chars("a", 6);
    add(" ", 1, 0, 0, 1, 2'b11, 1, 7, 0);
    add_chars("b", 7);
    add(" ", 1, 0, 0, 1, 2'b11, 1, 8, 0);
    // flush alone terminates a keyword prefix as OTHER
    add_chars("bE", 8);
    add(8'h00, 0, 1, 0, 1, 2'b11, 2, 9, 0);
    // stall inside "end" keeps state and length
    add_chars("en", 9);
    add("x", 0, 0, 0, 0, 2'b00, 0, 9, 1);
    add_chars("d", 9);
    add(" ", 1, 0, 0, 1, 2'b10, 3, 10, 0);
    // "beg" with in_valid toggling, then reset mid-word
    add_chars("b", 10);
    add("z", 0, 0, 0, 0, 2'b00, 0, 10, 1);
    add_chars("e", 10);
    add("z", 0, 0, 0, 0, 2'b00, 0, 10, 1);
    add_chars("g", 10);
    add(" ", 0, 0, 1, 0, 2'b00, 0, 0, 0);
    add(" ", 1, 0, 0, 0, 2'b00, 0, 0, 0);

    foreach (vq[i]) begin
      step(vq[i].c, vq[i].v, vq[i].f, vq[i].r);
      checks++;
      if ({tok_valid, tok_type, tok_len, tok_cnt, busy} !==
          {vq[i].ev, vq[i].et, vq[i].el, vq[i].ec, vq[i].eb}) begin
        errors++;
        $display("FAIL vec%0d ch=%h: got v=%0b t=%b l=%0d c=%0d busy=%0b, expected v=%0b t=%b l=%0d c=%0d busy=%0b",
                 i, vq[i].c, tok_valid, tok_type, tok_len, tok_cnt, busy,
                 vq[i].ev, vq[i].et, vq[i].el, vq[i].ec, vq[i].eb);
      end
    end

    // Narrow instance: length/count saturation, tab as a word char
    step(8'h00, 0, 0, 1);
    check2("n_reset", 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 9; i++) step("x", 1, 0, 0);
    check2("n_9x_busy", 0, 2'b00, 0, 0, 1);
    step(" ", 1, 0, 0);
    check2("n_len_sat", 1, 2'b11, 3'd7, 2'd1, 0);
    step("e", 1, 0, 0);
    step("n", 1, 0, 0);
    step("d", 1, 0, 0);
    step(8'h09, 1, 0, 0);
    check2("n_tab_char", 0, 2'b00, 0, 2'd1, 1);
    step(" ", 1, 0, 0);
    check2("n_end_tab", 1, 2'b11, 3'd4, 2'd2, 0);
    step("a", 1, 0, 0);
    step(" ", 1, 0, 0);
    check2("n_cnt3", 1, 2'b11, 3'd1, 2'd3, 0);
    step("a", 1, 0, 0);
    step(" ", 1, 0, 0);
    check2("n_cnt_sat", 1, 2'b11, 3'd1, 2'd3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
